// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Pointer, flag and occupancy controller for a single-clock FIFO
//               built around an external memory. The memory has a synchronous
//               write port and a combinational read port. Reads are
//               first-word fall-through: the word at r_addr is the head of the
//               queue whenever the FIFO is not empty.
//
// Parameters  : DEPTH     - number of memory entries (power of two, >= 4)
//               AF_LEVEL  - occupancy at or above which almost_full asserts
//               AE_LEVEL  - occupancy at or below which almost_empty asserts
//
// Ports       : clk          in   single clock, rising edge
//               rst          in   synchronous active-high reset
//               wr_en        in   push request from the producer
//               rd_en        in   pop request from the consumer
//               mem_we       out  memory write enable (combinational)
//               w_addr       out  memory write address
//               r_addr       out  memory read address
//               full         out  occupancy == DEPTH
//               empty        out  occupancy == 0
//               almost_full  out  occupancy >= AF_LEVEL
//               almost_empty out  occupancy <= AE_LEVEL
//               count        out  current occupancy (registered)
//               overflow     out  sticky: a push was rejected
//               underflow    out  sticky: a pop was rejected
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic                       mem_we,
    output logic [$clog2(DEPTH)-1:0]   w_addr,
    output logic [$clog2(DEPTH)-1:0]   r_addr,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_AW = $clog2(DEPTH);

    // Thresholds brought to the count width once so the compares are exact.
    localparam logic [c_AW:0] c_AF_LVL = (c_AW + 1)'(AF_LEVEL);
    localparam logic [c_AW:0] c_AE_LVL = (c_AW + 1)'(AE_LEVEL);
    localparam logic [c_AW:0] c_ONE    = (c_AW + 1)'(1);

    // Pointers carry one extra wrap bit above the address bits, so equal
    // addresses can be told apart as "empty" (wrap equal) or "full" (differ).
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [c_AW:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_overflow_evt;
    logic          w_underflow_evt;

    // ------------------------------------------------------------------------
    // Status decode from the pointers
    // ------------------------------------------------------------------------
    always_comb begin
        w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                  (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
        w_empty = (r_wr_ptr == r_rd_ptr);
    end

    // ------------------------------------------------------------------------
    // Accept decisions
    // A push into a full FIFO is allowed when a pop is taken in the same
    // cycle: the head word is read combinationally before the edge and the
    // new word lands on that same address at the edge. A pop from an empty
    // FIFO is never taken, even with a concurrent push, because the word
    // being pushed is not in memory until the edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_overflow_evt  = 1'b0;
        w_underflow_evt = 1'b0;
        if (!rst) begin
            w_push          = wr_en && (!w_full || rd_en);
            w_pop           = rd_en && !w_empty;
            w_overflow_evt  = wr_en && w_full && !rd_en;
            w_underflow_evt = rd_en && w_empty;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end

            // Occupancy moves by at most one per cycle; a paired push and
            // pop leaves it where it is.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase

            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_we       = w_push;
        w_addr       = r_wr_ptr[c_AW-1:0];
        r_addr       = r_rd_ptr[c_AW-1:0];
        full         = w_full;
        empty        = w_empty;
        count        = r_count;
        almost_full  = (r_count >= c_AF_LVL);
        almost_empty = (r_count <= c_AE_LVL);
        overflow     = r_overflow;
        underflow    = r_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Self-checking bench for sync_fifo_ctrl (DEPTH=8, AF_LEVEL=6,
//               AE_LEVEL=2). An external memory with a combinational read
//               port is modelled here; a queue-based reference tracks contents,
//               occupancy, sticky flags and total push/pop counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int c_DEPTH = 8;
    localparam int c_AF    = 6;
    localparam int c_AE    = 2;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       mem_we;
    logic [2:0] w_addr;
    logic [2:0] r_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] wr_data;
    logic [7:0] mem [c_DEPTH];
    logic [7:0] r_data;

    sync_fifo_ctrl #(
        .DEPTH    (c_DEPTH),
        .AF_LEVEL (c_AF),
        .AE_LEVEL (c_AE)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .mem_we       (mem_we),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we) mem[w_addr] <= wr_data;
    end
    assign r_data = mem[r_addr];

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_unf;
    int         m_pushes;
    int         m_pops;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs before the edge,
    // advance the model at the edge, check registered outputs after it.
    task automatic cycle(input bit wr, input bit rd, input bit rs, input logic [7:0] d);
        bit exp_push;
        bit exp_pop;
        bit was_full;
        bit was_empty;
        wr_en   = wr;
        rd_en   = rd;
        rst     = rs;
        wr_data = d;
        was_full  = (q.size() == c_DEPTH);
        was_empty = (q.size() == 0);
        exp_push  = !rs && wr && (!was_full || rd);
        exp_pop   = !rs && rd && !was_empty;
        @(negedge clk);
        check("mem_we", int'(mem_we), int'(exp_push));
        if (exp_pop) check("r_data", int'(r_data), int'(q[0]));
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf    = 0;
            m_unf    = 0;
            m_pushes = 0;
            m_pops   = 0;
        end else begin
            if (exp_pop) begin
                void'(q.pop_front());
                m_pops++;
            end
            if (exp_push) begin
                q.push_back(d);
                m_pushes++;
            end
            if (wr && was_full && !rd) m_ovf = 1;
            if (rd && was_empty) m_unf = 1;
        end
        #1;
        check("count",        int'(count),        q.size());
        check("full",         int'(full),         int'(q.size() == c_DEPTH));
        check("empty",        int'(empty),        int'(q.size() == 0));
        check("almost_full",  int'(almost_full),  int'(q.size() >= c_AF));
        check("almost_empty", int'(almost_empty), int'(q.size() <= c_AE));
        check("overflow",     int'(overflow),     int'(m_ovf));
        check("underflow",    int'(underflow),    int'(m_unf));
        check("w_addr",       int'(w_addr),       m_pushes % c_DEPTH);
        check("r_addr",       int'(r_addr),       m_pops % c_DEPTH);
    endtask

    initial begin
        int p_wr;
        int p_rd;
        n_checks = 0;
        n_fail   = 0;
        m_ovf    = 0;
        m_unf    = 0;
        m_pushes = 0;
        m_pops   = 0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

        // Reset
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);
        check("mem_we_after_reset", int'(mem_we), 0);

        // Fill with 0x10..0x17
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h10 + i));
        check("full_after_fill", int'(full), 1);

        // Push while full and no pop: rejected, overflow sets
        cycle(1, 0, 0, 8'hEE);
        check("overflow_set", int'(overflow), 1);

        // Drain in order
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'h00);
        check("empty_after_drain", int'(empty), 1);

        // Push+pop on empty: push only, underflow sets; next cycle head visible
        cycle(1, 1, 0, 8'h5A);
        check("underflow_set", int'(underflow), 1);
        check("fwft_head", int'(r_data), 8'h5A);
        cycle(0, 1, 0, 8'h00);

        // Refill, then push+pop while full with 0xAA, then drain
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h20 + i));
        cycle(1, 1, 0, 8'hAA);
        check("count_full_pushpop", int'(count), 8);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'h00);

        // Interleaved traffic across the wrap, then reset with wr_en high
        for (int i = 0; i < 20; i++) cycle(1, (i % 3) != 0, 0, 8'(8'h40 + i));
        cycle(1, 0, 1, 8'hFF);
        check("empty_after_midreset", int'(empty), 1);

        // Random run with traffic bias changing every 100 cycles
        p_wr = 50;
        p_rd = 50;
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) begin
                p_wr = $urandom_range(20, 90);
                p_rd = $urandom_range(20, 90);
            end
            cycle(($urandom % 100) < p_wr, ($urandom % 100) < p_rd, 0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
